evm_result_display: RTL and testbench

Downstream consumer of the vote-counting state machine's twelve 29-bit tally counters. The operator steps through the tallies with next/prev buttons. The selected tally is converted to 9-digit BCD by a sequential double-dabble engine and exported as a parallel BCD word. The same value is also time-multiplexed onto a 9-digit 7-segment display.

---
 rtl/evm_result_display.sv | 328 ++++++++++++++++++++++++++++++++
 tb/tb_evm_result_display.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/evm_result_display.sv
// ---------------------------------------------------------------------------
// evm_result_display
//
// Purpose:
//   Result viewer for the voting machine. The operator steps through the
//   twelve tally counters with next/prev buttons. The selected tally is
//   converted to packed BCD by a bit-serial double-dabble engine and
//   published as a parallel word. The same word is also scanned onto a
//   multiplexed 7-segment display.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   show_next, show_prev  conditioned button levels; rising edge steps index
//   counter_*             twelve CNT_W-bit tally inputs (index map below)
//   sel_idx               currently selected tally index (0..11)
//   bcd_out, bcd_idx      latest BCD result (digit 0 in [3:0]) and its index
//   bcd_valid             one-cycle pulse when bcd_out/bcd_idx update
//   busy                  conversion in progress (LOAD/SHIFT)
//   an, seg               one-hot digit enable and gfedcba segments, active high
//
// Index map: 0 A, 1 B, 2 total, 3 DC_A, 4 DC_B, 5 DC_total,
//            6 MD_A, 7 MD_B, 8 MD_total, 9 VA_A, 10 VA_B, 11 VA_total
//
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, digits above the most significant
//                          nonzero digit are blanked (digit 0 never blanks).
// ---------------------------------------------------------------------------
module evm_result_display #(
    parameter int CNT_W       = 29,
    parameter int DIGITS      = 9,
    parameter int REFRESH_CYC = 1024,
    parameter int SCAN_DIV    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                show_next,
    input  logic                show_prev,
    input  logic [CNT_W-1:0]    counter_A,
    input  logic [CNT_W-1:0]    counter_B,
    input  logic [CNT_W-1:0]    counter_total,
    input  logic [CNT_W-1:0]    counter_DC_A,
    input  logic [CNT_W-1:0]    counter_DC_B,
    input  logic [CNT_W-1:0]    counter_DC_total,
    input  logic [CNT_W-1:0]    counter_MD_A,
    input  logic [CNT_W-1:0]    counter_MD_B,
    input  logic [CNT_W-1:0]    counter_MD_total,
    input  logic [CNT_W-1:0]    counter_VA_A,
    input  logic [CNT_W-1:0]    counter_VA_B,
    input  logic [CNT_W-1:0]    counter_VA_total,
    output logic [3:0]          sel_idx,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic [3:0]          bcd_idx,
    output logic                bcd_valid,
    output logic                busy,
    output logic [DIGITS-1:0]   an,
    output logic [6:0]          seg
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int BIT_W  = $clog2(CNT_W);
    localparam int REF_W  = $clog2(REFRESH_CYC);
    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int POS_W  = $clog2(DIGITS);
    localparam logic [3:0] LAST_IDX = 4'd11;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t             state_q, state_d;
    logic               nextSync_q, nextDly_q, prevSync_q, prevDly_q;
    logic [3:0]         selIdx_q, selIdx_d;
    logic               pending_q, pending_d;
    logic [REF_W-1:0]   refCnt_q;
    logic [CNT_W-1:0]   binShift_q;
    logic [BCD_W-1:0]   acc_q;
    logic [3:0]         convIdx_q;
    logic [BIT_W-1:0]   bitCnt_q;
    logic [BCD_W-1:0]   bcdOut_q;
    logic [3:0]         bcdIdx_q;
    logic               dispEn_q;
    logic [SCAN_W-1:0]  scanDiv_q;
    logic [POS_W-1:0]   scanPos_q;

    logic               stepNext, stepPrev, refTick, lastShift, blankDigit;
    logic [CNT_W-1:0]   selTally;
    logic [BCD_W-1:0]   adjAcc, accShifted;
    logic [3:0]         curDigit;

    // Button levels are registered twice; a rising edge is a 1 in the first
    // stage with a 0 behind it. Simultaneous next+prev edges cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nextSync_q <= 1'b0;
            nextDly_q  <= 1'b0;
            prevSync_q <= 1'b0;
            prevDly_q  <= 1'b0;
        end else begin
            nextSync_q <= show_next;
            nextDly_q  <= nextSync_q;
            prevSync_q <= show_prev;
            prevDly_q  <= prevSync_q;
        end
    end

    assign stepNext = (nextSync_q & ~nextDly_q) & ~(prevSync_q & ~prevDly_q);
    assign stepPrev = (prevSync_q & ~prevDly_q) & ~(nextSync_q & ~nextDly_q);

    // Selected index walks 0..11 with wrap in both directions.
    always_comb begin
        selIdx_d = selIdx_q;
        if (stepNext) begin
            selIdx_d = (selIdx_q == LAST_IDX) ? 4'd0 : selIdx_q + 4'd1;
        end else if (stepPrev) begin
            selIdx_d = (selIdx_q == 4'd0) ? LAST_IDX : selIdx_q - 4'd1;
        end
    end

    // Free-running refresh counter; its terminal count requests a reconversion.
    assign refTick = (refCnt_q == REF_W'(REFRESH_CYC - 1));

    // Single-entry request flag. A new request in the same cycle that IDLE
    // consumes the old one wins, so no request is ever dropped.
    always_comb begin
        pending_d = pending_q;
        if (state_q == IDLE && pending_q) begin
            pending_d = 1'b0;
        end
        if (stepNext || stepPrev || refTick) begin
            pending_d = 1'b1;
        end
    end

    // Index, request flag and refresh counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            selIdx_q  <= 4'd0;
            pending_q <= 1'b1;
            refCnt_q  <= '0;
        end else begin
            selIdx_q  <= selIdx_d;
            pending_q <= pending_d;
            refCnt_q  <= refTick ? '0 : refCnt_q + REF_W'(1);
        end
    end

    // Tally multiplexer, sampled only while in LOAD.
    always_comb begin
        selTally = '0;
        case (selIdx_q)
            4'd0:    selTally = counter_A;
            4'd1:    selTally = counter_B;
            4'd2:    selTally = counter_total;
            4'd3:    selTally = counter_DC_A;
            4'd4:    selTally = counter_DC_B;
            4'd5:    selTally = counter_DC_total;
            4'd6:    selTally = counter_MD_A;
            4'd7:    selTally = counter_MD_B;
            4'd8:    selTally = counter_MD_total;
            4'd9:    selTally = counter_VA_A;
            4'd10:   selTally = counter_VA_B;
            4'd11:   selTally = counter_VA_total;
            default: selTally = '0;
        endcase
    end

    // Double-dabble step: add 3 to every digit >= 5, then shift the binary
    // MSB into the bottom of the BCD accumulator.
    always_comb begin
        adjAcc = acc_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (acc_q[4*d +: 4] >= 4'd5) begin
                adjAcc[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
            end
        end
        accShifted = {adjAcc[BCD_W-2:0], binShift_q[CNT_W-1]};
    end

    assign lastShift = (bitCnt_q == BIT_W'(CNT_W - 1));

    // Conversion FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Conversion FSM next-state and status outputs.
    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        bcd_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                busy    = 1'b1;
                state_d = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (lastShift) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Conversion datapath. The result registers load on the final shift so
    // that bcd_out is already current during the DONE (bcd_valid) cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            binShift_q <= '0;
            acc_q      <= '0;
            convIdx_q  <= 4'd0;
            bitCnt_q   <= '0;
            bcdOut_q   <= '0;
            bcdIdx_q   <= 4'd0;
        end else begin
            case (state_q)
                LOAD: begin
                    binShift_q <= selTally;
                    acc_q      <= '0;
                    convIdx_q  <= selIdx_q;
                    bitCnt_q   <= '0;
                end
                SHIFT: begin
                    acc_q      <= accShifted;
                    binShift_q <= {binShift_q[CNT_W-2:0], 1'b0};
                    bitCnt_q   <= bitCnt_q + BIT_W'(1);
                    if (lastShift) begin
                        bcdOut_q <= accShifted;
                        bcdIdx_q <= convIdx_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Display scan: stays dark until the first result exists, then rotates
    // through the digits without ever restarting on a new result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dispEn_q  <= 1'b0;
            scanDiv_q <= '0;
            scanPos_q <= '0;
        end else begin
            if (state_q == DONE) begin
                dispEn_q <= 1'b1;
            end
            if (dispEn_q) begin
                if (scanDiv_q == SCAN_W'(SCAN_DIV - 1)) begin
                    scanDiv_q <= '0;
                    scanPos_q <= (scanPos_q == POS_W'(DIGITS - 1)) ? '0
                                                                   : scanPos_q + POS_W'(1);
                end else begin
                    scanDiv_q <= scanDiv_q + SCAN_W'(1);
                end
            end
        end
    end

    // Digit currently being shown.
    always_comb begin
        curDigit = 4'd0;
        for (int d = 0; d < DIGITS; d++) begin
            if (scanPos_q == POS_W'(d)) begin
                curDigit = bcdOut_q[4*d +: 4];
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [POS_W-1:0] msdPos;

    // Highest nonzero digit position; zero when the whole value is zero so
    // digit 0 always stays visible.
    always_comb begin
        msdPos = '0;
        for (int d = 1; d < DIGITS; d++) begin
            if (bcdOut_q[4*d +: 4] != 4'd0) begin
                msdPos = POS_W'(d);
            end
        end
    end

    assign blankDigit = (scanPos_q > msdPos);
`else
    assign blankDigit = 1'b0;
`endif

    function automatic logic [6:0] hexToSeg(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    assign an      = dispEn_q ? (DIGITS'(1) << scanPos_q) : '0;
    assign seg     = (dispEn_q && !blankDigit) ? hexToSeg(curDigit) : 7'h00;
    assign sel_idx = selIdx_q;
    assign bcd_out = bcdOut_q;
    assign bcd_idx = bcdIdx_q;

endmodule

// File: tb/tb_evm_result_display.sv
// ---------------------------------------------------------------------------
// tb_evm_result_display
//
// Scoreboard bench for evm_result_display. Each request the bench causes
// pushes its expected {index, BCD} into a queue; a negedge monitor pops and
// compares on every bcd_valid. Expected BCD comes from decimal arithmetic on
// the tally value, and expected segments from a digit lookup table.
// ---------------------------------------------------------------------------
module tb_evm_result_display;

    localparam logic [6:0] SEG_TABLE [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    typedef struct {
        logic [3:0]  idx;
        logic [35:0] bcd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        show_next = 1'b0;
    logic        show_prev = 1'b0;
    logic [28:0] cnt [12];
    logic [3:0]  sel_idx;
    logic [35:0] bcd_out;
    logic [3:0]  bcd_idx;
    logic        bcd_valid;
    logic        busy;
    logic [8:0]  an;
    logic [6:0]  seg;

    exp_t expQ[$];
    int   validCycles[$];
    int   checks = 0;
    int   failures = 0;
    int   cycleCount = 0;
    int   relCycle = 0;
    int   modelSel = 0;

    evm_result_display dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .show_next        (show_next),
        .show_prev        (show_prev),
        .counter_A        (cnt[0]),
        .counter_B        (cnt[1]),
        .counter_total    (cnt[2]),
        .counter_DC_A     (cnt[3]),
        .counter_DC_B     (cnt[4]),
        .counter_DC_total (cnt[5]),
        .counter_MD_A     (cnt[6]),
        .counter_MD_B     (cnt[7]),
        .counter_MD_total (cnt[8]),
        .counter_VA_A     (cnt[9]),
        .counter_VA_B     (cnt[10]),
        .counter_VA_total (cnt[11]),
        .sel_idx          (sel_idx),
        .bcd_out          (bcd_out),
        .bcd_idx          (bcd_idx),
        .bcd_valid        (bcd_valid),
        .busy             (busy),
        .an               (an),
        .seg              (seg)
    );

    // Free-running clock and cycle counter for latency measurement.
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount++;

    function automatic logic [35:0] toBcd(input logic [28:0] v);
        logic [35:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int d = 0; d < 9; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s", name);
    endtask

    task automatic pushExp(input int idx);
        exp_t e;
        e.idx = 4'(idx);
        e.bcd = toBcd(cnt[idx]);
        expQ.push_back(e);
    endtask

    // Monitor: every result pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bcd_valid === 1'b1) begin
            validCycles.push_back(cycleCount);
            if (expQ.size() == 0) begin
                failNow("unexpected_bcd_valid");
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("bcd_idx", 64'(bcd_idx), 64'(e.idx));
                checkOutput("bcd_out", 64'(bcd_out), 64'(e.bcd));
            end
        end
    end

    // Reset with reset-value checks; release leaves the index-0 conversion expected.
    task automatic applyReset();
        @(negedge clk);
        rst_n = 1'b0;
        show_next = 1'b0;
        show_prev = 1'b0;
        expQ.delete();
        repeat (2) @(negedge clk);
        checkOutput("rst_sel_idx", 64'(sel_idx), 64'd0);
        checkOutput("rst_bcd_out", 64'(bcd_out), 64'd0);
        checkOutput("rst_bcd_idx", 64'(bcd_idx), 64'd0);
        checkOutput("rst_bcd_valid", 64'(bcd_valid), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_an", 64'(an), 64'd0);
        checkOutput("rst_seg", 64'(seg), 64'd0);
        modelSel = 0;
        pushExp(0);
        validCycles.delete();
        @(negedge clk);
        rst_n = 1'b1;
        relCycle = cycleCount;
    endtask

    task automatic applyStimulus(input bit doNext, input bit doPrev);
        @(negedge clk);
        show_next = doNext;
        show_prev = doPrev;
        repeat (3) @(negedge clk);
        show_next = 1'b0;
        show_prev = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        while (expQ.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (expQ.size() != 0) begin
            failNow("wait_timeout");
            expQ.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic checkFirstLatency(input string name);
        if (validCycles.size() == 0) failNow(name);
        else checkOutput(name, 64'(validCycles[0] - relCycle), 64'd31);
    endtask

    // Watches a full scan rotation and checks each lit digit's segments.
    task automatic displayCheck(input logic [28:0] v);
        logic [35:0] b;
        logic [8:0]  seen;
        logic [6:0]  expSeg;
        int          limit;
        int unsigned x;
        int          pos;
        b = toBcd(v);
        seen = '0;
        limit = 8;
`ifdef LEADING_ZERO_BLANK_EN
        limit = 0;
        x = v;
        while (x >= 10) begin
            x = x / 10;
            limit++;
        end
`endif
        repeat (160) begin
            @(negedge clk);
            checkOutput("an_onehot", 64'($onehot(an)), 64'd1);
            pos = -1;
            for (int d = 0; d < 9; d++) if (an[d]) pos = d;
            if (pos >= 0) begin
                seen[pos] = 1'b1;
                expSeg = (pos > limit) ? 7'h00 : SEG_TABLE[int'(b[4*pos +: 4])];
                checkOutput($sformatf("seg_digit%0d", pos), 64'(seg), 64'(expSeg));
            end
        end
        checkOutput("scan_coverage", 64'(seen), 64'h1FF);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog_timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        int sz;
        int d;
        bit dir;
        for (int k = 0; k < 12; k++) cnt[k] = 29'($urandom);

        // Scenario 1: first conversion latency, dark display, scan, refresh.
        cnt[0] = 29'd12345;
        applyReset();
        repeat (10) @(negedge clk);
        checkOutput("busy_during_shift", 64'(busy), 64'd1);
        checkOutput("an_dark_before_first", 64'(an), 64'd0);
        checkOutput("seg_dark_before_first", 64'(seg), 64'd0);
        waitDone(60);
        checkFirstLatency("first_latency");
        checkOutput("busy_after_done", 64'(busy), 64'd0);
        displayCheck(cnt[0]);
        pushExp(0);
        waitDone(1200);
        if (validCycles.size() < 2) failNow("refresh_missing");
        else begin
            d = validCycles[1] - relCycle;
            checkOutput("refresh_window", 64'(d >= 1024 && d <= 1060), 64'd1);
        end

        // Scenario 2: wrap in both directions, cancelled double edge, random walk.
        cnt[11] = 29'h1FFFFFFF;
        applyReset();
        waitDone(60);
        modelSel = 11;
        pushExp(11);
        applyStimulus(1'b0, 1'b1);
        waitDone(80);
        checkOutput("sel_wrap_prev", 64'(sel_idx), 64'd11);
        modelSel = 0;
        pushExp(0);
        applyStimulus(1'b1, 1'b0);
        waitDone(80);
        checkOutput("sel_wrap_next", 64'(sel_idx), 64'd0);
        modelSel = 11;
        pushExp(11);
        applyStimulus(1'b0, 1'b1);
        waitDone(80);
        sz = validCycles.size();
        applyStimulus(1'b1, 1'b1);
        repeat (50) @(negedge clk);
        checkOutput("both_edges_sel", 64'(sel_idx), 64'd11);
        checkOutput("both_edges_no_conv", 64'(validCycles.size()), 64'(sz));
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 12; k++) cnt[k] = 29'($urandom);
            dir = 1'($urandom_range(0, 1));
            modelSel = dir ? (modelSel + 1) % 12 : (modelSel + 11) % 12;
            pushExp(modelSel);
            applyStimulus(dir, !dir);
            waitDone(80);
            checkOutput("sel_walk", 64'(sel_idx), 64'(modelSel));
        end
        displayCheck(cnt[modelSel]);

        // Scenario 3: step during a conversion, tally changing mid-flight.
        for (int k = 0; k < 12; k++) cnt[k] = 29'($urandom);
        applyReset();
        pushExp(1);
        repeat (4) @(negedge clk);
        applyStimulus(1'b1, 1'b0);
        cnt[0] = cnt[0] + 29'd7;
        waitDone(120);
        checkOutput("mid_conv_sel", 64'(sel_idx), 64'd1);
        checkOutput("mid_conv_count", 64'(validCycles.size()), 64'd2);
        if (validCycles.size() == 2)
            checkOutput("second_valid_gap", 64'(validCycles[1] - validCycles[0]), 64'd32);

        // Scenario 4: reset in the middle of a conversion.
        applyReset();
        waitDone(60);
        pushExp(1);
        applyStimulus(1'b1, 1'b0);
        repeat (8) @(negedge clk);
        checkOutput("busy_before_abort", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        expQ.delete();
        #1;
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_bcd_out", 64'(bcd_out), 64'd0);
        checkOutput("abort_an", 64'(an), 64'd0);
        checkOutput("abort_valid", 64'(bcd_valid), 64'd0);
        applyReset();
        waitDone(60);
        checkFirstLatency("after_abort_latency");

        // Scenario 5: display patterns, including leading zeros and zero.
        cnt[0] = 29'd407;
        applyReset();
        waitDone(60);
        displayCheck(cnt[0]);
        cnt[0] = 29'd0;
        applyReset();
        waitDone(60);
        displayCheck(cnt[0]);
        cnt[0] = 29'($urandom_range(1, 99999));
        applyReset();
        waitDone(60);
        displayCheck(cnt[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
